// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - IMEM/DMEM responder for the pipelined CPU with a host image loader.
module cpu_mem_responder #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_datain,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_dataout,
  input  logic          d_we,
  output logic [DW-1:0] d_datain,
  input  logic          ld_start,
  input  logic          ld_target,
  input  logic [AW-1:0] ld_base,
  input  logic [AW:0]   ld_count,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          cpu_hold
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] REM_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t          state;
  logic            target;
  logic [AW-1:0]   ptr;
  logic [AW:0]     rem;
  logic [AW:0]     count_sat;
  logic            accept;
  logic            imem_ld_we;
  logic            dmem_ld_we;
  logic            cpu_we;

  logic [DW-1:0]   imem [DEPTH];
  logic [DW-1:0]   dmem [DEPTH];

  assign i_datain = imem[i_addr];
  assign d_datain = dmem[d_addr];

  assign count_sat  = (ld_count > DEPTH_W) ? DEPTH_W : ld_count;
  // A word offered on the same edge as reset is dropped: the aborted load never resumes.
  assign accept     = (state == S_LOAD) && ld_valid && reset;
  assign imem_ld_we = accept && !target;
  assign dmem_ld_we = accept && target;
  assign cpu_we     = (state == S_IDLE) && d_we;

  always_ff @(posedge clock) begin
    if (imem_ld_we) begin
      imem[ptr] <= ld_data;
    end
  end

  always_ff @(posedge clock) begin
    if (dmem_ld_we) begin
      dmem[ptr] <= ld_data;
    end else if (cpu_we) begin
      dmem[d_addr] <= d_dataout;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_IDLE;
      target   <= 1'b0;
      ptr      <= '0;
      rem      <= '0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ld_done <= 1'b0;
          if (ld_start) begin
            target   <= ld_target;
            ptr      <= ld_base;
            rem      <= count_sat;
            cpu_hold <= 1'b1;
            if (count_sat == '0) begin
              state    <= S_DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end else begin
              state    <= S_LOAD;
              ld_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            ptr <= ptr + 1'b1;
            rem <= rem - 1'b1;
            if (rem == REM_ONE) begin
              state    <= S_DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          ld_done  <= 1'b0;
          cpu_hold <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          ld_ready <= 1'b0;
          ld_done  <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - directed vector bench for cpu_mem_responder.
module tb_cpu_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  i_addr;
  logic [15:0] i_datain;
  logic [7:0]  d_addr;
  logic [15:0] d_dataout;
  logic        d_we;
  logic [15:0] d_datain;
  logic        ld_start;
  logic        ld_target;
  logic [7:0]  ld_base;
  logic [8:0]  ld_count;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        cpu_hold;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  cpu_mem_responder #(.AW(8), .DW(16)) dut (
    .clock(clock), .reset(reset),
    .i_addr(i_addr), .i_datain(i_datain),
    .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(d_datain),
    .ld_start(ld_start), .ld_target(ld_target), .ld_base(ld_base), .ld_count(ld_count),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
    .cpu_hold(cpu_hold)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic        tgt;
    logic [7:0]  base;
    logic [8:0]  cnt;
    logic        valid;
    logic [15:0] data;
    logic [7:0]  ia;
    logic [7:0]  da;
    logic        we;
    logic [15:0] dout;
    logic [2:0]  exp_rdh;   // {ld_ready, ld_done, cpu_hold} during this cycle
    logic        ci;
    logic [15:0] ei;
    logic        cd;
    logic [15:0] edv;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic st, logic tg, logic [7:0] b, logic [8:0] cn,
                              logic vl, logic [15:0] dt, logic [7:0] ia, logic [7:0] da,
                              logic we, logic [15:0] dout, logic [2:0] e,
                              logic ci, logic [15:0] ei, logic cd, logic [15:0] edv);
    vec_t v;
    v.rst = rst; v.start = st; v.tgt = tg; v.base = b; v.cnt = cn; v.valid = vl; v.data = dt;
    v.ia = ia; v.da = da; v.we = we; v.dout = dout; v.exp_rdh = e;
    v.ci = ci; v.ei = ei; v.cd = cd; v.edv = edv;
    return v;
  endfunction

  function automatic vec_t v_rst();
    return mk(1'b0, 0, 0, 8'h0, 9'h0, 0, 16'h0, 8'h0, 8'h0, 0, 16'h0, 3'b000, 0, 16'h0, 0, 16'h0);
  endfunction
  function automatic vec_t v_ctl(logic st, logic tg, logic [7:0] b, logic [8:0] cn,
                                 logic vl, logic [15:0] dt, logic [2:0] e);
    return mk(1'b1, st, tg, b, cn, vl, dt, 8'h0, 8'h0, 0, 16'h0, e, 0, 16'h0, 0, 16'h0);
  endfunction
  function automatic vec_t v_cw(logic vl, logic [15:0] dt, logic [7:0] da, logic [15:0] dout,
                                logic [2:0] e);
    return mk(1'b1, 0, 0, 8'h0, 9'h0, vl, dt, 8'h0, da, 1'b1, dout, e, 0, 16'h0, 0, 16'h0);
  endfunction
  function automatic vec_t v_rd(logic [7:0] da, logic [15:0] edv);
    return mk(1'b1, 0, 0, 8'h0, 9'h0, 0, 16'h0, 8'h0, da, 0, 16'h0, 3'b000, 0, 16'h0, 1'b1, edv);
  endfunction
  function automatic vec_t v_ri(logic [7:0] ia, logic [15:0] ei);
    return mk(1'b1, 0, 0, 8'h0, 9'h0, 0, 16'h0, ia, 8'h0, 0, 16'h0, 3'b000, 1'b1, ei, 0, 16'h0);
  endfunction
  function automatic vec_t v_st(logic [7:0] da, logic [15:0] dout);
    return mk(1'b1, 0, 0, 8'h0, 9'h0, 0, 16'h0, 8'h0, da, 1'b1, dout, 3'b000, 0, 16'h0, 0, 16'h0);
  endfunction
  function automatic vec_t v_stc(logic [7:0] da, logic [15:0] dout, logic [15:0] edv);
    return mk(1'b1, 0, 0, 8'h0, 9'h0, 0, 16'h0, 8'h0, da, 1'b1, dout, 3'b000, 0, 16'h0, 1'b1, edv);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; ld_start = v.start; ld_target = v.tgt; ld_base = v.base; ld_count = v.cnt;
    ld_valid = v.valid; ld_data = v.data; i_addr = v.ia; d_addr = v.da; d_we = v.we;
    d_dataout = v.dout;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " ready"}, {31'b0, ld_ready}, {31'b0, v.exp_rdh[2]});
    chk({tag, " done"},  {31'b0, ld_done},  {31'b0, v.exp_rdh[1]});
    chk({tag, " hold"},  {31'b0, cpu_hold}, {31'b0, v.exp_rdh[0]});
    if (v.ci) chk({tag, " i_datain"}, {16'b0, i_datain}, {16'b0, v.ei});
    if (v.cd) chk({tag, " d_datain"}, {16'b0, d_datain}, {16'b0, v.edv});
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clock);
    apply(v);
    #1;
    check_vec(tag, v);
  endtask

  initial begin
    int  n;
    bit  done_seen;
    apply(v_rst());

    // reset state
    vq.push_back(v_rst());
    vq.push_back(v_rst());
    // IMEM load of 4 words, valid every cycle
    vq.push_back(v_ctl(1, 0, 8'h00, 9'd4, 0, 16'h0,    3'b000));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 1, 16'h4108, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 1, 16'h4209, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 1, 16'h0800, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 1, 16'h0800, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 0, 16'h0,    3'b011));
    vq.push_back(v_ri(8'h01, 16'h4209));
    vq.push_back(v_ri(8'h00, 16'h4108));
    vq.push_back(v_ri(8'h03, 16'h0800));
    // DMEM load wrapping past 0xFF
    vq.push_back(v_ctl(1, 1, 8'hFE, 9'd3, 0, 16'h0,    3'b000));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 1, 16'hA0A0, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 1, 16'hB0B0, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 1, 16'hC0C0, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 0, 16'h0,    3'b011));
    vq.push_back(v_rd(8'hFE, 16'hA0A0));
    vq.push_back(v_rd(8'hFF, 16'hB0B0));
    vq.push_back(v_rd(8'h00, 16'hC0C0));
    // backpressure: valid 1,0,0,1
    vq.push_back(v_st(8'h22, 16'h5A5A));
    vq.push_back(v_ctl(1, 1, 8'h20, 9'd2, 0, 16'h0,    3'b000));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 1, 16'h1111, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 0, 16'h9999, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 0, 16'h9999, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 1, 16'h2222, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 0, 16'h9999, 3'b011));
    vq.push_back(v_rd(8'h20, 16'h1111));
    vq.push_back(v_rd(8'h21, 16'h2222));
    vq.push_back(v_rd(8'h22, 16'h5A5A));
    // CPU store: old value same cycle, new value next cycle, ignored while loading
    vq.push_back(v_st(8'h10, 16'h1111));
    vq.push_back(v_stc(8'h10, 16'hBEEF, 16'h1111));
    vq.push_back(v_rd(8'h10, 16'hBEEF));
    vq.push_back(v_ctl(1, 1, 8'h60, 9'd1, 0, 16'h0, 3'b000));
    vq.push_back(v_cw(0, 16'h0,    8'h10, 16'hDEAD, 3'b101));
    vq.push_back(v_cw(1, 16'h6666, 8'h10, 16'hDEAD, 3'b101));
    vq.push_back(v_cw(0, 16'h0,    8'h10, 16'hDEAD, 3'b011));
    vq.push_back(v_rd(8'h10, 16'hBEEF));
    vq.push_back(v_rd(8'h60, 16'h6666));
    // count=0, then ld_start while busy
    vq.push_back(v_st(8'h30, 16'h7777));
    vq.push_back(v_ctl(1, 1, 8'h30, 9'd0, 0, 16'h0, 3'b000));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 0, 16'h0, 3'b011));
    vq.push_back(v_rd(8'h30, 16'h7777));
    vq.push_back(v_st(8'h50, 16'h1234));
    vq.push_back(v_ctl(1, 1, 8'h40, 9'd1, 0, 16'h0,    3'b000));
    vq.push_back(v_ctl(1, 1, 8'h50, 9'd3, 0, 16'h0,    3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 1, 16'hAAAA, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 0, 16'h0,    3'b011));
    vq.push_back(v_rd(8'h40, 16'hAAAA));
    vq.push_back(v_rd(8'h50, 16'h1234));
    // marker word for the reset-abort sequence below
    vq.push_back(v_ctl(1, 0, 8'h82, 9'd1, 0, 16'h0,    3'b000));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 1, 16'h0BAD, 3'b101));
    vq.push_back(v_ctl(0, 0, 8'h00, 9'd0, 0, 16'h0,    3'b011));
    vq.push_back(v_ri(8'h82, 16'h0BAD));

    foreach (vq[k]) begin
      step($sformatf("row%0d", k), vq[k]);
    end

    // reset mid-load after 2 of 5 words
    step("rst_a", v_ctl(1, 0, 8'h80, 9'd5, 0, 16'h0,    3'b000));
    step("rst_b", v_ctl(0, 0, 8'h00, 9'd0, 1, 16'h1001, 3'b101));
    step("rst_c", v_ctl(0, 0, 8'h00, 9'd0, 1, 16'h1002, 3'b101));
    step("rst_d", mk(1'b0, 0, 0, 8'h0, 9'h0, 1, 16'h1003, 8'h0, 8'h0, 0, 16'h0, 3'b101,
                     0, 16'h0, 0, 16'h0));
    for (int i = 0; i < 4; i++) begin
      step($sformatf("rst_after%0d", i), v_ctl(0, 0, 8'h00, 9'd0, 1, 16'h1004, 3'b000));
    end
    step("rst_w0", v_ri(8'h80, 16'h1001));
    step("rst_w1", v_ri(8'h81, 16'h1002));
    step("rst_w2", v_ri(8'h82, 16'h0BAD));

    // oversized count saturates to 256 words
    step("sat_start", v_ctl(1, 0, 8'h00, 9'h1FF, 0, 16'h0, 3'b000));
    n = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(negedge clock);
      ld_start = 1'b0;
      ld_valid = 1'b1;
      ld_data  = 16'h5000 + 16'(n);
      #1;
      if (ld_done) done_seen = 1'b1;
      else if (ld_ready) n++;
    end
    chk("sat_done_seen", {31'b0, done_seen}, 32'd1);
    chk("sat_words", n, 32'd256);
    step("sat_idle", v_ri(8'h00, 16'h5000));
    step("sat_last", v_ri(8'hFF, 16'h50FF));
    step("sat_mid",  v_ri(8'h03, 16'h5003));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
